mmu_ctrl: RTL and testbench

- Configuration and fault-tracking controller for the core's base/offset memory protection unit.
- Holds software-writable shadow copies of enable, mask, offset and size, and drives the unit's active configuration.
- Swaps shadow into active atomically, only after in-flight memory accesses drain, stalling new accesses meanwhile.
- Captures protection faults reported by the unit: sticky flag, first faulting address, saturating count.

---
 rtl/mmu_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mmu_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_ctrl.sv
// Configuration and fault-tracking controller for the base/offset protection unit.
// Shadow config is swapped into the active set only after in-flight accesses drain.
module mmu_ctrl #(
    parameter int DRAIN_TIMEOUT = 16,
    parameter int FAULT_CNT_W   = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        csr_we_i,
    input  logic [2:0]  csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_ready_o,
    output logic [31:0] csr_rdata_o,
    input  logic        mem_busy_i,
    input  logic        access_valid_i,
    input  logic        exception_i,
    input  logic [31:0] fault_addr_i,
    output logic        en_o,
    output logic [31:0] mask_o,
    output logic [31:0] offset_o,
    output logic [31:0] size_o,
    output logic        stall_o,
    output logic        commit_done_o,
    output logic        fault_o
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] SWAP  = 2'd2;

    localparam int CNT_W = $clog2(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       drain_cnt_q, drain_cnt_d;
    logic                   en_sh_q, en_q;
    logic [31:0]            mask_sh_q, offset_sh_q, size_sh_q;
    logic [31:0]            mask_q, offset_q, size_q;
    logic                   done_q;
    logic                   fault_q, fault_d;
    logic                   timeout_q, timeout_d;
    logic [31:0]            fault_addr_q, fault_addr_d;
    logic [FAULT_CNT_W-1:0] fcnt_q, fcnt_d;

    logic csr_wr, ctrl_wr, commit_req, clear_req, swap, timeout_set, fault_ev;

    assign csr_ready_o = (state_q == IDLE);
    assign stall_o     = (state_q != IDLE);
    assign csr_wr      = csr_we_i & csr_ready_o;
    assign ctrl_wr     = csr_wr & (csr_addr_i == 3'd3);
    assign commit_req  = ctrl_wr & csr_wdata_i[1];
    assign clear_req   = ctrl_wr & csr_wdata_i[2];
    assign fault_ev    = access_valid_i & exception_i;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        swap        = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (commit_req) begin
                    state_d     = DRAIN;
                    drain_cnt_d = '0;
                end
            end
            DRAIN: begin
                if (!mem_busy_i) begin
                    state_d = SWAP;
                end else if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = IDLE;
                    timeout_set = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            SWAP: begin
                swap    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A clear in the same cycle as a fault wins; the fault is dropped.
    always_comb begin
        fault_d      = fault_q;
        timeout_d    = timeout_q | timeout_set;
        fault_addr_d = fault_addr_q;
        fcnt_d       = fcnt_q;
        if (clear_req) begin
            fault_d      = 1'b0;
            timeout_d    = 1'b0;
            fault_addr_d = '0;
            fcnt_d       = '0;
        end else if (fault_ev) begin
            if (!fault_q) fault_addr_d = fault_addr_i;
            fault_d = 1'b1;
            if (!(&fcnt_q)) fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            drain_cnt_q  <= '0;
            en_sh_q      <= 1'b0;
            mask_sh_q    <= '0;
            offset_sh_q  <= '0;
            size_sh_q    <= '0;
            en_q         <= 1'b0;
            mask_q       <= '0;
            offset_q     <= '0;
            size_q       <= '0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            timeout_q    <= 1'b0;
            fault_addr_q <= '0;
            fcnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            done_q       <= swap;
            fault_q      <= fault_d;
            timeout_q    <= timeout_d;
            fault_addr_q <= fault_addr_d;
            fcnt_q       <= fcnt_d;
            if (csr_wr) begin
                case (csr_addr_i)
                    3'd0:    mask_sh_q   <= csr_wdata_i;
                    3'd1:    offset_sh_q <= csr_wdata_i;
                    3'd2:    size_sh_q   <= csr_wdata_i;
                    3'd3:    en_sh_q     <= csr_wdata_i[0];
                    default: ;
                endcase
            end
            if (swap) begin
                en_q     <= en_sh_q;
                mask_q   <= mask_sh_q;
                offset_q <= offset_sh_q;
                size_q   <= size_sh_q;
            end
        end
    end

    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            3'd0: csr_rdata_o = mask_sh_q;
            3'd1: csr_rdata_o = offset_sh_q;
            3'd2: csr_rdata_o = size_sh_q;
            3'd3: begin
                csr_rdata_o      = 32'(fcnt_q) << 16;
                csr_rdata_o[3:0] = {timeout_q, fault_q, stall_o, en_q};
            end
            3'd4: csr_rdata_o = fault_addr_q;
            default: csr_rdata_o = '0;
        endcase
    end

    assign en_o          = en_q;
    assign mask_o        = mask_q;
    assign offset_o      = offset_q;
    assign size_o        = size_q;
    assign commit_done_o = done_q;
    assign fault_o       = fault_q;

endmodule

// File: tb/tb_mmu_ctrl.sv
// Randomized bench for mmu_ctrl checked against a transaction-level model of
// the commit handshake and fault capture rules.
module tb_mmu_ctrl;

    localparam int DT      = 16;
    localparam int CW      = 16;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        csr_we_i;
    logic [2:0]  csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic        csr_ready_o;
    logic [31:0] csr_rdata_o;
    logic        mem_busy_i;
    logic        access_valid_i;
    logic        exception_i;
    logic [31:0] fault_addr_i;
    logic        en_o;
    logic [31:0] mask_o, offset_o, size_o;
    logic        stall_o, commit_done_o, fault_o;

    always #5 clk = ~clk;

    mmu_ctrl #(.DRAIN_TIMEOUT(DT), .FAULT_CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n),
        .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
        .csr_ready_o(csr_ready_o), .csr_rdata_o(csr_rdata_o),
        .mem_busy_i(mem_busy_i), .access_valid_i(access_valid_i),
        .exception_i(exception_i), .fault_addr_i(fault_addr_i),
        .en_o(en_o), .mask_o(mask_o), .offset_o(offset_o), .size_o(size_o),
        .stall_o(stall_o), .commit_done_o(commit_done_o), .fault_o(fault_o)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int stall_cnt, done_cnt;

    // Reference model: shadow/active config, commit progress, fault record.
    logic [31:0] sh_mask, sh_off, sh_size, a_mask, a_off, a_size, m_faddr;
    bit          sh_en, a_en, m_fault, m_timeout, m_done;
    int          m_cnt;
    bit          committing;   // commit accepted, active set not yet replaced
    bit          swap_next;    // memory was seen idle; replacement happens next edge
    int          busy_seen;    // busy cycles observed while waiting to drain

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sh_mask = '0; sh_off = '0; sh_size = '0; sh_en = 0;
        a_mask = '0; a_off = '0; a_size = '0; a_en = 0;
        m_faddr = '0; m_fault = 0; m_timeout = 0; m_done = 0; m_cnt = 0;
        committing = 0; swap_next = 0; busy_seen = 0;
    endtask

    function automatic logic [31:0] exp_rdata(input logic [2:0] a);
        case (a)
            3'd0: return sh_mask;
            3'd1: return sh_off;
            3'd2: return sh_size;
            3'd3: return (32'(m_cnt) << 16) | (32'(m_timeout) << 3) | (32'(m_fault) << 2)
                         | (32'(committing) << 1) | 32'(a_en);
            3'd4: return m_faddr;
            default: return 32'h0;
        endcase
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    task automatic model_update();
        bit accept, clr;
        accept = csr_we_i && !committing;
        clr    = 0;
        m_done = 0;
        if (committing) begin
            if (swap_next) begin
                a_en = sh_en; a_mask = sh_mask; a_off = sh_off; a_size = sh_size;
                m_done = 1; committing = 0; swap_next = 0;
            end else if (!mem_busy_i) begin
                swap_next = 1;
            end else begin
                busy_seen++;
                if (busy_seen == DT) begin
                    committing = 0;
                    m_timeout  = 1;
                end
            end
        end
        if (accept) begin
            case (csr_addr_i)
                3'd0: sh_mask = csr_wdata_i;
                3'd1: sh_off  = csr_wdata_i;
                3'd2: sh_size = csr_wdata_i;
                3'd3: begin
                    sh_en = csr_wdata_i[0];
                    clr   = csr_wdata_i[2];
                    if (csr_wdata_i[1]) begin
                        committing = 1; swap_next = 0; busy_seen = 0;
                    end
                end
                default: ;
            endcase
        end
        if (clr) begin
            m_fault = 0; m_timeout = 0; m_faddr = '0; m_cnt = 0;
        end else if (access_valid_i && exception_i) begin
            if (!m_fault) m_faddr = fault_addr_i;
            m_fault = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
    endtask

    task automatic compare_all();
        check_eq("ready",  32'(csr_ready_o),   32'(!committing));
        check_eq("stall",  32'(stall_o),       32'(committing));
        check_eq("done",   32'(commit_done_o), 32'(m_done));
        check_eq("en",     32'(en_o),          32'(a_en));
        check_eq("mask",   mask_o,             a_mask);
        check_eq("offset", offset_o,           a_off);
        check_eq("size",   size_o,             a_size);
        check_eq("fault",  32'(fault_o),       32'(m_fault));
        check_eq("rdata",  csr_rdata_o,        exp_rdata(csr_addr_i));
    endtask

    task automatic step(input bit chk);
        @(negedge clk);
        if (chk) compare_all();
        if (stall_o) stall_cnt++;
        if (commit_done_o) done_cnt++;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [31:0] d);
        csr_we_i = 1; csr_addr_i = a; csr_wdata_i = d;
        step(1);
        csr_we_i = 0;
    endtask

    initial begin
        logic [31:0] wd;
        int busy_mode;
        reset_n = 0; csr_we_i = 0; csr_addr_i = 3'd3; csr_wdata_i = '0;
        mem_busy_i = 0; access_valid_i = 0; exception_i = 0; fault_addr_i = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state
        check_eq("rst_ctrl",  csr_rdata_o, 32'h0);
        check_eq("rst_ready", 32'(csr_ready_o), 32'h1);
        check_eq("rst_en",    32'(en_o), 32'h0);
        check_eq("rst_mask",  mask_o | offset_o | size_o, 32'h0);
        csr_addr_i = 3'd4;
        #1 check_eq("rst_faddr", csr_rdata_o, 32'h0);
        reset_n = 1;
        @(posedge clk); model_update(); #1;

        // Commit with idle memory
        csr_write(3'd0, 32'hFFFF0000);
        csr_write(3'd1, 32'h00010000);
        csr_write(3'd2, 32'h00000FFF);
        stall_cnt = 0; done_cnt = 0;
        csr_write(3'd3, 32'h3);
        repeat (4) step(1);
        check_eq("t2_stall_cycles", stall_cnt, 2);
        check_eq("t2_done_pulses",  done_cnt, 1);
        check_eq("t2_en",   32'(en_o), 32'h1);
        check_eq("t2_mask", mask_o, 32'hFFFF0000);
        check_eq("t2_off",  offset_o, 32'h00010000);
        check_eq("t2_size", size_o, 32'h00000FFF);

        // Commit while memory stays busy, with writes dropped during the stall
        stall_cnt = 0; done_cnt = 0;
        mem_busy_i = 1;
        csr_write(3'd3, 32'h3);
        repeat (4) begin
            csr_we_i = 1; csr_addr_i = 3'd0; csr_wdata_i = 32'h1;
            step(1);
        end
        csr_we_i = 0; mem_busy_i = 0;
        repeat (4) step(1);
        check_eq("t3_stall_cycles", stall_cnt, 6);
        check_eq("t3_done_pulses",  done_cnt, 1);
        csr_addr_i = 3'd0;
        step(1);
        check_eq("t3_shadow_mask", csr_rdata_o, 32'hFFFF0000);

        // Drain timeout: memory never goes idle
        csr_write(3'd0, 32'h12345678);
        stall_cnt = 0; done_cnt = 0;
        mem_busy_i = 1;
        csr_write(3'd3, 32'h3);
        repeat (20) step(1);
        mem_busy_i = 0;
        check_eq("t4_stall_cycles", stall_cnt, DT);
        check_eq("t4_done_pulses",  done_cnt, 0);
        check_eq("t4_mask_kept",    mask_o, 32'hFFFF0000);
        csr_addr_i = 3'd3;
        #1 check_eq("t4_timeout_bit", 32'(csr_rdata_o[3]), 32'h1);

        // Fault capture
        access_valid_i = 1; exception_i = 1;
        for (int i = 1; i <= 3; i++) begin
            fault_addr_i = 32'h80000000 + 32'(i * 16);
            step(1);
        end
        access_valid_i = 0;
        step(1);
        exception_i = 0;
        csr_addr_i = 3'd4;
        #1 check_eq("t5_faddr", csr_rdata_o, 32'h80000010);
        csr_addr_i = 3'd3;
        #1 check_eq("t5_count", 32'(csr_rdata_o[31:16]), 32'd3);
        check_eq("t5_fault", 32'(fault_o), 32'h1);

        // Clear coincident with a fault, then saturation
        access_valid_i = 1; exception_i = 1; fault_addr_i = 32'hDEADBEEF;
        csr_write(3'd3, 32'h5);
        access_valid_i = 0; exception_i = 0;
        check_eq("t6_fault_clr", 32'(fault_o), 32'h0);
        csr_addr_i = 3'd3;
        #1 check_eq("t6_ctrl_clr", csr_rdata_o, 32'h1);
        csr_addr_i = 3'd4;
        #1 check_eq("t6_faddr_clr", csr_rdata_o, 32'h0);
        access_valid_i = 1; exception_i = 1; fault_addr_i = 32'h00000040;
        repeat (65537) step(0);
        access_valid_i = 0; exception_i = 0;
        csr_addr_i = 3'd3;
        step(1);
        check_eq("t6_saturated", 32'(csr_rdata_o[31:16]), 32'hFFFF);

        // Randomized traffic against the model
        busy_mode = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) busy_mode = $urandom_range(0, 2);
            csr_we_i   = ($urandom_range(0, 3) == 0);
            csr_addr_i = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (csr_addr_i == 3'd3) wd[2] = ($urandom_range(0, 7) == 0);
            csr_wdata_i    = wd;
            mem_busy_i     = (busy_mode == 2) ? 1'b1 : (busy_mode == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            access_valid_i = 1'($urandom_range(0, 1));
            exception_i    = ($urandom_range(0, 2) == 0);
            fault_addr_i   = $urandom;
            step(1);
        end
        csr_we_i = 0; access_valid_i = 0; exception_i = 0; mem_busy_i = 0;
        repeat (4) step(1);

        // Asynchronous reset in the middle of a drain
        mem_busy_i = 1;
        csr_write(3'd3, 32'h3);
        repeat (2) step(1);
        #3 reset_n = 0;
        model_reset();
        #1;
        check_eq("arst_stall", 32'(stall_o), 32'h0);
        check_eq("arst_ready", 32'(csr_ready_o), 32'h1);
        check_eq("arst_en",    32'(en_o), 32'h0);
        mem_busy_i = 0;
        @(negedge clk);
        reset_n = 1;
        @(posedge clk); model_update(); #1;
        csr_addr_i = 3'd3;
        repeat (4) step(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
